// File: rtl/counter_updown_param.sv
// counter_updown_param: parametrised up/down counter with wrap or saturate ends,
// synchronous clear/load, cascade terminal count, wrap pulse and sticky overflow.
module counter_updown_param #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             u_d,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_d, count_q;
    logic             wrap_d, wrap_q, ovf_d, ovf_q, at_end;

    always_comb begin
        at_end  = u_d ? (count_q == MAX) : (count_q == '0);
        tc      = en & ~clr & ~load & at_end;
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = (load_val > MAX) ? MAX : load_val;
        end else if (en && !at_end) begin
            count_d = u_d ? count_q + 1'b1 : count_q - 1'b1;
        end else if (en) begin
            // at a range end: wrap to the opposite end or hold, flagging either way
            ovf_d   = 1'b1;
            wrap_d  = !SATURATE;
            count_d = SATURATE ? count_q : (u_d ? '0 : MAX);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_counter_updown_param.sv
// tb_counter_updown_param: directed and random checks of counter_updown_param
// (default, MAX_VAL=9, saturating and a two-stage cascade) against an integer model.
module tb_counter_updown_param;
    logic clk = 1'b0, reset = 1'b0, en = 1'b0, u_d = 1'b0, clr = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] c0, c9, cs, ch;
    logic t0, t9, ts, th, w0, w9, ws, wh, o0, o9, os, oh;
    int n_cmp = 0, n_bad = 0;

    typedef struct { int c; bit w; bit o; } st_t;
    st_t m0, m9, ms, mh;

    always #5 clk = ~clk;

    counter_updown_param d0 (.clk(clk), .reset(reset), .en(en), .u_d(u_d), .clr(clr), .load(load),
        .load_val(load_val), .count(c0), .tc(t0), .wrap(w0), .ovf(o0));
    counter_updown_param #(.MAX_VAL(9)) d9 (.clk(clk), .reset(reset), .en(en), .u_d(u_d), .clr(clr),
        .load(load), .load_val(load_val), .count(c9), .tc(t9), .wrap(w9), .ovf(o9));
    counter_updown_param #(.SATURATE(1'b1)) ds (.clk(clk), .reset(reset), .en(en), .u_d(u_d), .clr(clr),
        .load(load), .load_val(load_val), .count(cs), .tc(ts), .wrap(ws), .ovf(os));
    counter_updown_param dh (.clk(clk), .reset(reset), .en(t0), .u_d(u_d), .clr(clr), .load(load),
        .load_val(load_val), .count(ch), .tc(th), .wrap(wh), .ovf(oh));

    function automatic st_t nxt(st_t s, int mx, bit sat, bit e, bit ud, bit cl, bit ld, int lv);
        st_t r = s;
        int t = s.c + (ud ? 1 : -1);
        r.w = 1'b0;
        if (cl) begin
            r.c = 0;
            r.o = 1'b0;
        end else if (ld) begin
            r.c = (lv > mx) ? mx : lv;
        end else if (e) begin
            if (t < 0 || t > mx) begin
                r.o = 1'b1;
                r.w = !sat;
                r.c = sat ? s.c : (t + mx + 1) % (mx + 1);
            end else r.c = t;
        end
        return r;
    endfunction

    function automatic bit mtc(st_t s, int mx, bit e, bit ud, bit cl, bit ld);
        return e && !cl && !ld && (ud ? s.c == mx : s.c == 0);
    endfunction

    task automatic zero_models();
        m0 = '{0, 1'b0, 1'b0}; m9 = m0; ms = m0; mh = m0;
    endtask

    task automatic tick();
        bit lo_tc = mtc(m0, 15, en, u_d, clr, load);
        @(posedge clk);
        if (reset) begin
            mh = nxt(mh, 15, 1'b0, lo_tc, u_d, clr, load, int'(load_val));
            m0 = nxt(m0, 15, 1'b0, en, u_d, clr, load, int'(load_val));
            m9 = nxt(m9, 9, 1'b0, en, u_d, clr, load, int'(load_val));
            ms = nxt(ms, 15, 1'b1, en, u_d, clr, load, int'(load_val));
        end else zero_models();
        #1;
    endtask

    task automatic test_reset_count();
        zero_models();
        en = 1'b1; u_d = 1'b1;
        #2;
        n_cmp++;
        if ({c0, w0, o0} !== 6'd0) begin n_bad++; $display("FAIL reset_hold: got %h want 0", {c0, w0, o0}); end
        #16 reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_cmp++;
            if (c0 !== 4'(k % 16) || w0 !== (k == 16) || o0 !== (k >= 16)) begin
                n_bad++;
                $display("FAIL up_count edge %0d: got c=%0d w=%b o=%b want c=%0d w=%b o=%b",
                         k, c0, w0, o0, k % 16, k == 16, k >= 16);
            end
        end
    endtask

    task automatic test_modulus();
        en = 1'b0; clr = 1'b1; tick(); clr = 1'b0; en = 1'b1; u_d = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            #1;
            n_cmp++;
            if (t9 !== (k - 1 == 9)) begin n_bad++; $display("FAIL mod_tc edge %0d: got %b want %b", k, t9, k - 1 == 9); end
            tick();
            n_cmp++;
            if (c9 !== 4'(k % 10)) begin n_bad++; $display("FAIL mod_count edge %0d: got %0d want %0d", k, c9, k % 10); end
        end
        u_d = 1'b0;
        #1;
        n_cmp++;
        if (t9 !== 1'b1) begin n_bad++; $display("FAIL mod_tc_down: got %b want 1", t9); end
        tick();
        n_cmp++;
        if (c9 !== 4'd9 || w9 !== 1'b1) begin n_bad++; $display("FAIL mod_down_wrap: got c=%0d w=%b want c=9 w=1", c9, w9); end
    endtask

    task automatic test_saturate();
        en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
        load = 1'b1; load_val = 4'hE; tick(); load = 1'b0;
        n_cmp++;
        if (cs !== 4'd14) begin n_bad++; $display("FAIL sat_load: got %0d want 14", cs); end
        en = 1'b1; u_d = 1'b1;
        tick(); tick();
        n_cmp++;
        if (cs !== 4'd15 || os !== 1'b1 || ws !== 1'b0) begin
            n_bad++; $display("FAIL sat_top: got c=%0d o=%b w=%b want c=15 o=1 w=0", cs, os, ws);
        end
        u_d = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_cmp++;
            if (cs !== 4'((15 - k < 0) ? 0 : 15 - k) || ws !== 1'b0) begin
                n_bad++; $display("FAIL sat_down edge %0d: got c=%0d w=%b want c=%0d w=0", k, cs, ws, (15 - k < 0) ? 0 : 15 - k);
            end
        end
    endtask

    task automatic test_priority();
        en = 1'b0; load = 1'b1; load_val = 4'd15; tick();
        load = 1'b0; en = 1'b1; u_d = 1'b1; tick();
        en = 1'b0; load = 1'b1; load_val = 4'd7; tick();
        n_cmp++;
        if (c0 !== 4'd7 || o0 !== 1'b1) begin n_bad++; $display("FAIL load_keeps_ovf: got c=%0d o=%b want c=7 o=1", c0, o0); end
        clr = 1'b1; en = 1'b1; tick();
        n_cmp++;
        if (c0 !== 4'd0 || o0 !== 1'b0) begin n_bad++; $display("FAIL clr_priority: got c=%0d o=%b want c=0 o=0", c0, o0); end
        clr = 1'b0; load_val = 4'd5; tick();
        n_cmp++;
        if (c0 !== 4'd5) begin n_bad++; $display("FAIL load_over_en: got %0d want 5", c0); end
        load_val = 4'd12; tick();
        n_cmp++;
        if (c9 !== 4'd9 || c0 !== 4'd12) begin n_bad++; $display("FAIL load_clamp: got c9=%0d c0=%0d want 9 12", c9, c0); end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_val = 4'd12; tick();
        load = 1'b0; en = 1'b1; u_d = 1'b1; tick();
        n_cmp++;
        if (c0 !== 4'd13 || w9 !== 1'b1) begin n_bad++; $display("FAIL pre_reset: got c0=%0d w9=%b want 13 1", c0, w9); end
        #2 reset = 1'b0;
        zero_models();
        #1;
        n_cmp++;
        if ({c0, w9, o9, o0} !== 7'd0) begin n_bad++; $display("FAIL async_reset: got %h want 0", {c0, w9, o9, o0}); end
        tick(); tick();
        n_cmp++;
        if ({c0, c9, w0, o0} !== 10'd0) begin n_bad++; $display("FAIL reset_held: got %h want 0", {c0, c9, w0, o0}); end
        reset = 1'b1;
    endtask

    task automatic test_cascade();
        logic [3:0] plo, phi;
        en = 1'b0; clr = 1'b1; tick(); clr = 1'b0; en = 1'b1; u_d = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            plo = c0; phi = ch;
            tick();
            n_cmp++;
            if (ch !== phi + 4'(plo == 4'd15)) begin n_bad++; $display("FAIL cascade_hi edge %0d: got %0d want %0d", k, ch, phi + 4'(plo == 4'd15)); end
        end
        n_cmp++;
        if ({ch, c0} !== 8'h28) begin n_bad++; $display("FAIL cascade_total: got %h want 28", {ch, c0}); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            en = $urandom_range(0, 3) != 0; u_d = $urandom_range(0, 1) != 0;
            clr = $urandom_range(0, 31) == 0; load = $urandom_range(0, 15) == 0;
            load_val = 4'($urandom);
            #1;
            n_cmp++;
            if ({t0, t9, ts, th} !== {mtc(m0, 15, en, u_d, clr, load), mtc(m9, 9, en, u_d, clr, load),
                                      mtc(ms, 15, en, u_d, clr, load),
                                      mtc(mh, 15, mtc(m0, 15, en, u_d, clr, load), u_d, clr, load)}) begin
                n_bad++; $display("FAIL rand_tc cycle %0d: got %b%b%b%b", k, t0, t9, ts, th);
            end
            tick();
            n_cmp++;
            if ({c0, w0, o0} !== {4'(m0.c), m0.w, m0.o}) begin n_bad++; $display("FAIL rand_d0 cycle %0d: got %h want %0d/%b/%b", k, {c0, w0, o0}, m0.c, m0.w, m0.o); end
            n_cmp++;
            if ({c9, w9, o9} !== {4'(m9.c), m9.w, m9.o}) begin n_bad++; $display("FAIL rand_d9 cycle %0d: got %h want %0d/%b/%b", k, {c9, w9, o9}, m9.c, m9.w, m9.o); end
            n_cmp++;
            if ({cs, ws, os} !== {4'(ms.c), ms.w, ms.o}) begin n_bad++; $display("FAIL rand_sat cycle %0d: got %h want %0d/%b/%b", k, {cs, ws, os}, ms.c, ms.w, ms.o); end
            n_cmp++;
            if ({ch, wh, oh} !== {4'(mh.c), mh.w, mh.o}) begin n_bad++; $display("FAIL rand_hi cycle %0d: got %h want %0d/%b/%b", k, {ch, wh, oh}, mh.c, mh.w, mh.o); end
        end
    endtask

    initial begin
        test_reset_count();
        test_modulus();
        test_saturate();
        test_priority();
        test_async_reset();
        test_cascade();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
